// File: rtl/inst_sequencer.sv
// -----------------------------------------------------------------------------
// inst_sequencer
//
// Multi-cycle instruction sequencer. It fetches a 16-bit instruction word,
// decodes its class from inst[15:13] and steps through
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB), driving the memory handshake, the
// IR/PC/register-file write enables and the datapath operand selectors.
//
// Optional feature (macro SEQ_MEM_TIMEOUT_EN):
//   When defined, a 4-bit wait counter runs while a memory request is
//   outstanding. If 15 consecutive request cycles see no mem_ack, the
//   sequencer parks in HALT with bus_err=1 and halted=1.
//   When undefined, memory requests wait forever and bus_err is constant 0.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-high reset
//   inst[15:0]     in   instruction word, valid with mem_ack during FETCH
//   mem_ack        in   single-cycle completion of the current mem_req
//   cond_true      in   branch condition, sampled in EXEC
//   mem_req        out  memory request, held until mem_ack
//   mem_we         out  memory write strobe (stores), held until mem_ack
//   ir_we          out  instruction register load
//   pc_we          out  program counter load
//   rf_we          out  register file write
//   rsrcA_sel[1:0] out  source register A field select
//   rsrcB_sel[1:0] out  source register B field select
//   rdest_sel      out  destination register field select
//   mem_inst       out  memory-immediate scaling select
//   pc_offset_sel  out  branch offset width select
//   alu_src_imm    out  ALU operand-B immediate select
//   state[2:0]     out  current state (debug)
//   halted         out  sticky: sequencer stopped in HALT
//   bus_err        out  sticky: memory timeout (0 without SEQ_MEM_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module inst_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] inst,
  input  logic        mem_ack,
  input  logic        cond_true,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic [1:0]  rsrcA_sel,
  output logic [1:0]  rsrcB_sel,
  output logic        rdest_sel,
  output logic        mem_inst,
  output logic        pc_offset_sel,
  output logic        alu_src_imm,
  output logic [2:0]  state,
  output logic        halted,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [2:0] CLS_ALU_REG = 3'b000;
  localparam logic [2:0] CLS_ALU_IMM = 3'b001;
  localparam logic [2:0] CLS_LDST    = 3'b011;
  localparam logic [2:0] CLS_BR_COND = 3'b110;
  localparam logic [2:0] CLS_BR_UNC  = 3'b111;

  state_t      state_q;
  logic [2:0]  cls_q;        // instruction class captured with the fetch
  logic        load_q;       // inst[11] captured with the fetch: 1 = load
  logic        req_q;
  logic        we_q;
  logic [1:0]  srca_q;
  logic [1:0]  srcb_q;
  logic        rdest_q;
  logic        meminst_q;
  logic        pcoff_q;
  logic        aluimm_q;
  logic        halted_q;

  // Only the class and load/store bit of the instruction steer sequencing.
  logic unused_inst_bits;
  assign unused_inst_bits = ^{inst[12], inst[10:0]};

`ifdef SEQ_MEM_TIMEOUT_EN
  logic [3:0]  wait_q;
  logic        bus_err_q;
  logic        tmo;

  // wait_q holds the number of already-elapsed unacknowledged request cycles,
  // so the 15th such cycle is the one where wait_q reads 14.
  assign tmo = req_q & ~mem_ack & (wait_q == 4'd14);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cls_q     <= 3'b000;
      load_q    <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      srca_q    <= 2'b00;
      srcb_q    <= 2'b00;
      rdest_q   <= 1'b0;
      meminst_q <= 1'b0;
      pcoff_q   <= 1'b0;
      aluimm_q  <= 1'b0;
      halted_q  <= 1'b0;
`ifdef SEQ_MEM_TIMEOUT_EN
      wait_q    <= 4'd0;
      bus_err_q <= 1'b0;
`endif
    end else begin
`ifdef SEQ_MEM_TIMEOUT_EN
      // Any cycle without an outstanding, unanswered request restarts the
      // count, so every new request begins from zero.
      wait_q <= (req_q && !mem_ack) ? wait_q + 4'd1 : 4'd0;
`endif
      case (state_q)
        S_FETCH: begin
          if (!req_q) begin
            // First cycle after reset: launch the fetch request.
            req_q <= 1'b1;
          end else if (mem_ack) begin
            cls_q   <= inst[15:13];
            load_q  <= inst[11];
            req_q   <= 1'b0;
            state_q <= S_DECODE;
          end
        end

        S_DECODE: begin
          state_q <= S_EXEC;
          case (cls_q)
            CLS_ALU_REG: begin
              srca_q    <= 2'b00;
              srcb_q    <= 2'b01;
              rdest_q   <= 1'b0;
              meminst_q <= 1'b0;
              pcoff_q   <= 1'b0;
              aluimm_q  <= 1'b0;
            end
            CLS_ALU_IMM: begin
              srca_q    <= 2'b10;
              srcb_q    <= 2'b00;
              rdest_q   <= 1'b1;
              meminst_q <= 1'b0;
              pcoff_q   <= 1'b0;
              aluimm_q  <= 1'b1;
            end
            CLS_LDST: begin
              srca_q    <= 2'b00;
              srcb_q    <= 2'b11;
              rdest_q   <= 1'b0;
              meminst_q <= 1'b1;
              pcoff_q   <= 1'b0;
              aluimm_q  <= 1'b1;
            end
            CLS_BR_COND: begin
              srca_q    <= 2'b00;
              srcb_q    <= 2'b00;
              rdest_q   <= 1'b0;
              meminst_q <= 1'b0;
              pcoff_q   <= 1'b0;
              aluimm_q  <= 1'b0;
            end
            CLS_BR_UNC: begin
              srca_q    <= 2'b00;
              srcb_q    <= 2'b00;
              rdest_q   <= 1'b0;
              meminst_q <= 1'b0;
              pcoff_q   <= 1'b1;
              aluimm_q  <= 1'b0;
            end
            default: begin
              // Undefined class: stop for good, selectors keep their values.
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end
          endcase
        end

        S_EXEC: begin
          case (cls_q)
            CLS_ALU_REG, CLS_ALU_IMM: begin
              state_q <= S_WB;
            end
            CLS_LDST: begin
              state_q <= S_MEM;
              req_q   <= 1'b1;
              we_q    <= ~load_q;
            end
            default: begin
              // Branches: PC load happens combinationally in this cycle.
              state_q <= S_FETCH;
              req_q   <= 1'b1;
            end
          endcase
        end

        S_MEM: begin
          if (mem_ack) begin
            we_q <= 1'b0;
            if (load_q) begin
              req_q   <= 1'b0;
              state_q <= S_WB;
            end else begin
              // Store completes here; the next fetch request follows at once.
              req_q   <= 1'b1;
              state_q <= S_FETCH;
            end
          end
        end

        S_WB: begin
          state_q <= S_FETCH;
          req_q   <= 1'b1;
        end

        S_HALT: begin
          state_q <= S_HALT;
        end

        default: begin
          // Unused encodings 5 and 6 are treated like a decode failure.
          state_q  <= S_HALT;
          req_q    <= 1'b0;
          we_q     <= 1'b0;
          halted_q <= 1'b1;
        end
      endcase

`ifdef SEQ_MEM_TIMEOUT_EN
      // Timeout overrides whatever the state case decided this cycle.
      if (tmo) begin
        state_q   <= S_HALT;
        req_q     <= 1'b0;
        we_q      <= 1'b0;
        halted_q  <= 1'b1;
        bus_err_q <= 1'b1;
      end
`endif
    end
  end

  // Strobes are decoded from the registered state; the FETCH and branch cases
  // also need the same-cycle mem_ack / cond_true. req_q gates the FETCH strobe
  // so an ack in the post-reset cycle (no request yet) is ignored.
  assign ir_we = (state_q == S_FETCH) & req_q & mem_ack;
  assign pc_we = ir_we |
                 ((state_q == S_EXEC) &
                  ((cls_q == CLS_BR_UNC) | ((cls_q == CLS_BR_COND) & cond_true)));
  assign rf_we = (state_q == S_WB);

  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign rsrcA_sel     = srca_q;
  assign rsrcB_sel     = srcb_q;
  assign rdest_sel     = rdest_q;
  assign mem_inst      = meminst_q;
  assign pc_offset_sel = pcoff_q;
  assign alu_src_imm   = aluimm_q;
  assign state         = state_q;
  assign halted        = halted_q;

`ifdef SEQ_MEM_TIMEOUT_EN
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_inst_sequencer
//
// Cycle-level scoreboard bench for inst_sequencer. Each driven cycle pushes
// the expected outputs for that cycle; a negedge monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_inst_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] inst = 16'h0000;
  logic        mem_ack = 1'b0;
  logic        cond_true = 1'b0;
  logic        mem_req, mem_we, ir_we, pc_we, rf_we;
  logic [1:0]  rsrcA_sel, rsrcB_sel;
  logic        rdest_sel, mem_inst, pc_offset_sel, alu_src_imm;
  logic [2:0]  state;
  logic        halted, bus_err;

  always #5 clk = ~clk;

  inst_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .inst          (inst),
    .mem_ack       (mem_ack),
    .cond_true     (cond_true),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .ir_we         (ir_we),
    .pc_we         (pc_we),
    .rf_we         (rf_we),
    .rsrcA_sel     (rsrcA_sel),
    .rsrcB_sel     (rsrcB_sel),
    .rdest_sel     (rdest_sel),
    .mem_inst      (mem_inst),
    .pc_offset_sel (pc_offset_sel),
    .alu_src_imm   (alu_src_imm),
    .state         (state),
    .halted        (halted),
    .bus_err       (bus_err)
  );

  // Selector mask bits: [0]rsrcA [1]rsrcB [2]rdest [3]mem_inst [4]pc_off [5]alu_imm
  typedef struct packed {
    logic [2:0] st;
    logic       req, we, irw, pcw, rfw, hlt, berr;
    logic [5:0] sm;
    logic [1:0] a, b;
    logic       rd, mi, po, ai;
  } exp_t;

  exp_t  sbq[$];
  string tagq[$];
  int    n_cmp = 0;
  int    n_err = 0;
  exp_t  mon_e;
  string mon_t;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // flags = {req, we, ir_we, pc_we, rf_we, halted, bus_err}
  function automatic exp_t ex(input logic [2:0] st, input logic [6:0] flags);
    exp_t e;
    e      = '0;
    e.st   = st;
    e.req  = flags[6];
    e.we   = flags[5];
    e.irw  = flags[4];
    e.pcw  = flags[3];
    e.rfw  = flags[2];
    e.hlt  = flags[1];
    e.berr = flags[0];
    return e;
  endfunction

  // Selector values each instruction class must present after DECODE.
  function automatic exp_t with_sel(input exp_t e0, input logic [15:0] i);
    exp_t e;
    e = e0;
    case (i[15:13])
      3'b000: begin e.sm = 6'b100111; e.a = 2'b00; e.b = 2'b01; e.rd = 1'b0; e.ai = 1'b0; end
      3'b001: begin e.sm = 6'b101101; e.a = 2'b10; e.rd = 1'b1; e.mi = 1'b0; e.ai = 1'b1; end
      3'b011: begin e.sm = 6'b101111; e.a = 2'b00; e.b = 2'b11; e.rd = 1'b0; e.mi = 1'b1; e.ai = 1'b1; end
      3'b110: begin e.sm = 6'b010000; e.po = 1'b0; end
      3'b111: begin e.sm = 6'b010000; e.po = 1'b1; end
      default: e.sm = 6'b000000;
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      mon_e = sbq.pop_front();
      mon_t = tagq.pop_front();
      chk({mon_t, ".state"},   {29'd0, state},  {29'd0, mon_e.st});
      chk({mon_t, ".mem_req"}, mem_req,         mon_e.req);
      chk({mon_t, ".mem_we"},  mem_we,          mon_e.we);
      chk({mon_t, ".ir_we"},   ir_we,           mon_e.irw);
      chk({mon_t, ".pc_we"},   pc_we,           mon_e.pcw);
      chk({mon_t, ".rf_we"},   rf_we,           mon_e.rfw);
      chk({mon_t, ".halted"},  halted,          mon_e.hlt);
      chk({mon_t, ".bus_err"}, bus_err,         mon_e.berr);
      if (mon_e.sm[0]) chk({mon_t, ".rsrcA"},   {30'd0, rsrcA_sel}, {30'd0, mon_e.a});
      if (mon_e.sm[1]) chk({mon_t, ".rsrcB"},   {30'd0, rsrcB_sel}, {30'd0, mon_e.b});
      if (mon_e.sm[2]) chk({mon_t, ".rdest"},   rdest_sel,     mon_e.rd);
      if (mon_e.sm[3]) chk({mon_t, ".mem_inst"}, mem_inst,     mon_e.mi);
      if (mon_e.sm[4]) chk({mon_t, ".pc_off"},  pc_offset_sel, mon_e.po);
      if (mon_e.sm[5]) chk({mon_t, ".alu_imm"}, alu_src_imm,   mon_e.ai);
    end
  end

  // Drive one cycle's inputs just after the rising edge and queue its expectation.
  task automatic cyc(input string tag, input logic [15:0] i, input logic ack,
                     input logic cnd, input exp_t e);
    @(posedge clk);
    #1;
    inst      = i;
    mem_ack   = ack;
    cond_true = cnd;
    sbq.push_back(e);
    tagq.push_back(tag);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    reset   = 1'b1;
    mem_ack = 1'b0;
    #1;
    chk({nm, ".state"},   {29'd0, state}, 32'd0);
    chk({nm, ".mem_req"}, mem_req, 32'd0);
    chk({nm, ".mem_we"},  mem_we, 32'd0);
    chk({nm, ".strobes"}, {29'd0, ir_we, pc_we, rf_we}, 32'd0);
    chk({nm, ".sels"},    {24'd0, rsrcA_sel, rsrcB_sel, rdest_sel, mem_inst,
                           pc_offset_sel, alu_src_imm}, 32'd0);
    chk({nm, ".halted"},  halted, 32'd0);
    chk({nm, ".bus_err"}, bus_err, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    // The release cycle itself carries no request yet.
    sbq.push_back(ex(3'd0, 7'b0000000));
    tagq.push_back({nm, ".release"});
  endtask

  // One complete instruction starting at its FETCH cycle (request already up).
  task automatic run_inst(input string nm, input logic [15:0] i, input int fw,
                          input int mw, input logic cnd, input logic stray);
    logic [2:0] c;
    logic       pcw;
    c   = i[15:13];
    pcw = (c == 3'b111) || ((c == 3'b110) && cnd);
    for (int k = 0; k < fw; k++)
      cyc({nm, ".fwait"}, i, 1'b0, cnd, ex(3'd0, 7'b1000000));
    cyc({nm, ".fetch"},  i,  1'b1,  cnd, ex(3'd0, 7'b1011000));
    cyc({nm, ".decode"}, ~i, stray, cnd, ex(3'd1, 7'b0000000));
    cyc({nm, ".exec"},   ~i, stray, cnd, with_sel(ex(3'd2, {3'b000, pcw, 3'b000}), i));
    if (c == 3'b011) begin
      for (int k = 0; k < mw; k++)
        cyc({nm, ".mwait"}, ~i, 1'b0, cnd, with_sel(ex(3'd3, {1'b1, ~i[11], 5'b00000}), i));
      cyc({nm, ".mack"}, ~i, 1'b1, cnd, with_sel(ex(3'd3, {1'b1, ~i[11], 5'b00000}), i));
    end
    if ((c == 3'b000) || (c == 3'b001) || ((c == 3'b011) && i[11]))
      cyc({nm, ".wb"}, ~i, stray, cnd, with_sel(ex(3'd4, 7'b0000100), i));
  endtask

  task automatic run_undef(input logic [15:0] i);
    cyc("undef.fetch",  i,  1'b1, 1'b0, ex(3'd0, 7'b1011000));
    cyc("undef.decode", ~i, 1'b0, 1'b0, ex(3'd1, 7'b0000000));
    for (int k = 0; k < 20; k++)
      cyc("undef.halt", ~i, k[0], 1'b1, ex(3'd7, 7'b0000010));
  endtask

  task automatic reset_in_mem();
    logic [15:0] i;
    i = 16'h6321;  // store: class 011, inst[11]=0
    cyc("rmem.fetch",  i,  1'b1, 1'b0, ex(3'd0, 7'b1011000));
    cyc("rmem.decode", ~i, 1'b0, 1'b0, ex(3'd1, 7'b0000000));
    cyc("rmem.exec",   ~i, 1'b0, 1'b0, with_sel(ex(3'd2, 7'b0000000), i));
    cyc("rmem.mwait",  ~i, 1'b0, 1'b0, with_sel(ex(3'd3, 7'b1100000), i));
    cyc("rmem.mwait",  ~i, 1'b0, 1'b0, with_sel(ex(3'd3, 7'b1100000), i));
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    chk("rmem.pre_req", {31'd0, mem_req}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("rmem.state",   {29'd0, state}, 32'd0);
    chk("rmem.mem_req", mem_req, 32'd0);
    chk("rmem.mem_we",  mem_we, 32'd0);
    chk("rmem.rsrcB",   {30'd0, rsrcB_sel}, 32'd0);
    chk("rmem.mem_inst", mem_inst, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sbq.push_back(ex(3'd0, 7'b0000000));
    tagq.push_back("rmem.release");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset("rst0");
    run_inst("alu",   16'h0011, 0, 0, 1'b0, 1'b1);
    run_inst("alui",  16'h2345, 2, 0, 1'b0, 1'b0);
    run_inst("ldr",   16'h6A5C, 0, 3, 1'b0, 1'b0);
    run_inst("str",   16'h6123, 1, 1, 1'b0, 1'b0);
    run_inst("bcc0",  16'hC012, 0, 0, 1'b0, 1'b1);
    run_inst("bcc1",  16'hC034, 0, 0, 1'b1, 1'b0);
    run_inst("bu",    16'hE0FF, 0, 0, 1'b0, 1'b0);
    run_inst("ldr0",  16'h6800, 0, 0, 1'b1, 1'b0);
    run_undef(16'h4000);
    do_reset("rst1");
    run_inst("post",  16'h0011, 0, 0, 1'b0, 1'b0);
    reset_in_mem();
    run_inst("fresh", 16'h2001, 0, 0, 1'b0, 1'b0);
`ifdef SEQ_MEM_TIMEOUT_EN
    for (int k = 0; k < 15; k++)
      cyc("tmo.wait", 16'h0000, 1'b0, 1'b0, ex(3'd0, 7'b1000000));
    cyc("tmo.halt", 16'h0000, 1'b0, 1'b0, ex(3'd7, 7'b0000011));
    cyc("tmo.stay", 16'h0000, 1'b1, 1'b0, ex(3'd7, 7'b0000011));
`else
    for (int k = 0; k < 100; k++)
      cyc("nomo.wait", 16'h0000, 1'b0, 1'b0, ex(3'd0, 7'b1000000));
`endif
    @(negedge clk);
    #1;
    chk("sb_drain", sbq.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
